// File: rtl/max_setter_pkg.sv
// Shared definitions for the bottle-capacity setter: FSM states, BCD limits
// and the index of each front-panel key in the key vectors.
package max_setter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  localparam int INC   = 0;
  localparam int DEC   = 1;
  localparam int SEL   = 2;
  localparam int OK    = 3;
  localparam int NKEYS = 4;

endpackage

// File: rtl/max_setter_key_debounce.sv
// One push-button front end: two-flop synchroniser, debounce counter that
// accepts a new level after DEB_CYCLES consecutive agreeing samples, and a
// registered single-cycle pulse on each accepted 0->1 transition.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic key,
  output logic pulse
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic       key_p0;
  logic       key_p1;
  logic       lvl_p2;
  logic [7:0] cnt_p2;

  // Synchronise the raw asynchronous button into the CLK domain.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      key_p0 <= 1'b0;
      key_p1 <= 1'b0;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  // --- stage p2: debounce counter, accepted level and rise pulse ---
  // The pulse is registered on the same edge that accepts the high level so
  // the action lands exactly one edge later.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lvl_p2 <= 1'b0;
      cnt_p2 <= 8'd0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (key_p1 == lvl_p2) begin
        cnt_p2 <= 8'd0;
      end else if (cnt_p2 >= CNT_LAST) begin
        lvl_p2 <= key_p1;
        cnt_p2 <= 8'd0;
        pulse  <= key_p1;
      end else begin
        cnt_p2 <= cnt_p2 + 8'd1;
      end
    end
  end

endmodule

// File: rtl/max_setter.sv
// Operator entry of the two-digit BCD bottle capacity. Debounced keys edit one
// digit at a time while EN_set is high; ok commits a non-zero value to
// maxH/maxL, and set qualifies the committed value whenever not editing.
module max_setter
  import max_setter_pkg::*;
#(
  parameter int         DEB_CYCLES = 4,
  parameter logic [3:0] DEF_H      = 4'd1,
  parameter logic [3:0] DEF_L      = 4'd0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       EN_set,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_sel,
  input  logic       key_ok,
  output logic [3:0] maxH,
  output logic [3:0] maxL,
  output logic       set,
  output logic [3:0] editH,
  output logic [3:0] editL,
  output logic       selH,
  output logic       err
);

  // Wrap-around digit step; any out-of-range value is forced back into BCD.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? BCD_ZERO : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == BCD_ZERO || d > BCD_MAX) ? BCD_MAX : d - 4'd1;
  endfunction

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] pulse;
  state_t           state;
  logic [3:0]       sel_digit;
  logic [3:0]       stepped;
  logic             step_vld;

  assign key_raw[INC] = key_inc;
  assign key_raw[DEC] = key_dec;
  assign key_raw[SEL] = key_sel;
  assign key_raw[OK]  = key_ok;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
      .CLK  (CLK),
      .RSTn (RSTn),
      .key  (key_raw[k]),
      .pulse(pulse[k])
    );
  end

  // Next value of the selected digit for a lone inc or dec pulse.
  always_comb begin
    sel_digit = selH ? editH : editL;
    step_vld  = pulse[INC] ^ pulse[DEC];
    stepped   = pulse[INC] ? bcd_inc(sel_digit) : bcd_dec(sel_digit);
  end

  // FSM with edit/commit registers; priority is abort > ok > sel > inc/dec.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      maxH  <= DEF_H;
      maxL  <= DEF_L;
      editH <= DEF_H;
      editL <= DEF_L;
      selH  <= 1'b0;
      set   <= 1'b1;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (EN_set) begin
            state <= EDIT;
            set   <= 1'b0;
            selH  <= 1'b0;
          end
        end
        EDIT: begin
          if (!EN_set) begin
            state <= IDLE;
            set   <= 1'b1;
            editH <= maxH;
            editL <= maxL;
          end else if (pulse[OK]) begin
            if ({editH, editL} != 8'h00) begin
              state <= IDLE;
              set   <= 1'b1;
              maxH  <= editH;
              maxL  <= editL;
            end else begin
              err <= 1'b1;
            end
          end else if (pulse[SEL]) begin
            selH <= ~selH;
          end else if (step_vld) begin
            if (selH) editH <= stepped;
            else      editL <= stepped;
          end
        end
        default: begin
          state <= IDLE;
          set   <= 1'b1;
        end
      endcase
    end
  end

endmodule
